// File: rtl/vector_alu_issue.sv
// Issue/sequencing front-end for a combinational 128-bit vector ALU: one op in flight, per-op hold.
// Optional VEC_ISSUE_ILLEGAL_EN: ops 6/7 bypass the ALU and return res_err=1 with zero data.
module vector_alu_issue #(
    parameter int N          = 128,
    parameter int TAG_W      = 4,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [N-1:0]     req_a,
    input  logic [N-1:0]     req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [2:0]       alu_sel,
    input  logic [N-1:0]     alu_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic [TAG_W-1:0] res_tag
`ifdef VEC_ISSUE_ILLEGAL_EN
    ,
    output logic             res_err
`endif
);
    localparam int MAXH  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXH) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rdy_q;
    logic             res_valid_q;
    logic [N-1:0]     alu_a_q, alu_b_q, res_data_q;
    logic [2:0]       alu_sel_q;
    logic [TAG_W-1:0] tag_q, res_tag_q;
    logic             res_err_q;

    // Remaining hold cycles after the first EXEC cycle.
    function automatic logic [CNT_W-1:0] hold_m1(input logic [2:0] op);
        case (op)
            3'd4:    return CNT_W'(MUL_CYCLES - 1);
            3'd5:    return CNT_W'(DIV_CYCLES - 1);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            res_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            tag_q       <= '0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (req_valid && rdy_q) begin
                        rdy_q <= 1'b0;
`ifdef VEC_ISSUE_ILLEGAL_EN
                        if (req_op[2:1] == 2'b11) begin
                            res_data_q  <= '0;
                            res_tag_q   <= req_tag;
                            res_err_q   <= 1'b1;
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else
`endif
                        begin
                            alu_a_q   <= req_a;
                            alu_b_q   <= req_b;
                            alu_sel_q <= req_op;
                            tag_q     <= req_tag;
                            cnt_q     <= hold_m1(req_op);
                            state_q   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        res_data_q  <= alu_c;
                        res_tag_q   <= tag_q;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        rdy_q       <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = rdy_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
`ifdef VEC_ISSUE_ILLEGAL_EN
    assign res_err   = res_err_q;
`else
    logic unused_err;
    assign unused_err = res_err_q;
`endif
endmodule

// File: tb/tb_vector_alu_issue.sv
// Directed scoreboard bench for vector_alu_issue; ALU stub: C = A^B for Sel 2, else A.
module tb_vector_alu_issue;
    localparam int N = 128;
    localparam int TAG_W = 4;

    logic clk = 0, rst_n = 1;
    logic req_valid = 0, req_ready, res_valid, res_ready = 1;
    logic [2:0] req_op = 0, alu_sel;
    logic [N-1:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_c, res_data;
    logic [TAG_W-1:0] req_tag = 0, res_tag;
`ifdef VEC_ISSUE_ILLEGAL_EN
    logic res_err;
`endif

    always #5 clk = ~clk;
    assign alu_c = (alu_sel == 3'd2) ? (alu_a ^ alu_b) : alu_a;

    vector_alu_issue #(.N(N), .TAG_W(TAG_W), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag)
`ifdef VEC_ISSUE_ILLEGAL_EN
        , .res_err(res_err)
`endif
    );

    typedef struct {
        logic [N-1:0]     d;
        logic [TAG_W-1:0] t;
        logic             e;
        int               lat;
    } exp_t;

    exp_t sbq[$];
    int tests = 0, fails = 0;
    logic [N-1:0] last_a = 0, last_b = 0;
    logic [2:0] last_sel = 0;

    task automatic check(input string name, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic bit illegal(input logic [2:0] op);
`ifdef VEC_ISSUE_ILLEGAL_EN
        return op >= 3'd6;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int hold(input logic [2:0] op);
        return (op == 3'd4) ? 2 : (op == 3'd5) ? 4 : 1;
    endfunction

    task automatic wait_ready();
        int i;
        for (i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        if (i == 20) check("req_ready_timeout", 0, 1);
    endtask

    // Drive one request at a negedge and push the expected result.
    task automatic start_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [TAG_W-1:0] tag);
        exp_t x;
        wait_ready();
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1;
        @(posedge clk);
        #1 req_valid = 0;
        x.t = tag;
        x.e = illegal(op);
        x.d = illegal(op) ? '0 : (op == 3'd2) ? (a ^ b) : a;
        x.lat = illegal(op) ? 1 : hold(op) + 1;
        sbq.push_back(x);
        if (!illegal(op)) begin
            last_a = a; last_b = b; last_sel = op;
        end
    endtask

    task automatic finish_op(input string name, input int bp);
        exp_t x;
        int i;
        logic [N-1:0] d0;
        logic [TAG_W-1:0] t0;
        for (i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) break;
            check({name, "_alu_a"}, alu_a, last_a);
            check({name, "_alu_b"}, alu_b, last_b);
            check({name, "_alu_sel"}, N'(alu_sel), N'(last_sel));
            check({name, "_rdy_exec"}, N'(req_ready), 0);
        end
        if (sbq.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
            return;
        end
        x = sbq.pop_front();
        check({name, "_latency"}, N'(i), N'(x.lat));
        check({name, "_data"}, res_data, x.d);
        check({name, "_tag"}, N'(res_tag), N'(x.t));
        check({name, "_alu_sel_done"}, N'(alu_sel), N'(last_sel));
`ifdef VEC_ISSUE_ILLEGAL_EN
        check({name, "_err"}, N'(res_err), N'(x.e));
`endif
        d0 = res_data; t0 = res_tag;
        for (int k = 0; k < bp; k++) begin
            req_valid = 1; req_op = 3'd2; req_tag = 4'hF;
            @(negedge clk);
            check({name, "_bp_valid"}, N'(res_valid), 1);
            check({name, "_bp_data"}, res_data, d0);
            check({name, "_bp_tag"}, N'(res_tag), N'(t0));
            check({name, "_bp_rdy"}, N'(req_ready), 0);
        end
        req_valid = 0;
        res_ready = 1;
        @(negedge clk);
        check({name, "_post_valid"}, N'(res_valid), 0);
        check({name, "_post_rdy"}, N'(req_ready), 1);
    endtask

    initial begin
        int seen;
        // Async reset observed without a clock edge
        #2 rst_n = 0;
        #1;
        check("rst_res_valid", N'(res_valid), 0);
        check("rst_res_data", res_data, 0);
        check("rst_alu_sel", N'(alu_sel), 0);
        check("rst_req_ready", N'(req_ready), 0);
        check("rst_res_tag", N'(res_tag), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        start_op(3'd2, 128'h0F0F, 128'h00FF, 4'd3);
        finish_op("add", 0);
        start_op(3'd5, 128'h1234_5678_9ABC_DEF0_0000_0000_0000_0001, 128'h55, 4'd5);
        finish_op("div", 0);
        start_op(3'd4, 128'hDEAD_BEEF, 128'h7, 4'd9);
        finish_op("mul", 0);
        start_op(3'd3, 128'hA5A5, 128'h1, 4'd1);
        finish_op("sub", 0);
        start_op(3'd0, 128'hFFFF_0000, 128'h3, 4'd0);
        finish_op("zero", 0);

        // Backpressure with a competing request that must be ignored
        res_ready = 0;
        start_op(3'd2, {64'hCAFE_F00D_0000_0001, 64'h8000_0000_0000_0000}, 128'hFFFF, 4'd12);
        finish_op("bp", 10);
        start_op(3'd1, 128'h42, 128'h99, 4'd6);
        finish_op("after_bp", 0);

        // Reset during EXEC of a divide discards it
        start_op(3'd5, 128'hBAD, 128'hBAD, 4'd7);
        void'(sbq.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_exec_valid", N'(res_valid), 0);
        check("rst_exec_alu_sel", N'(alu_sel), 0);
        last_a = 0; last_b = 0; last_sel = 0;
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen = 1;
        end
        check("no_result_after_rst", N'(seen), 0);
        start_op(3'd1, 128'h1357_9BDF, 128'h2468, 4'd2);
        finish_op("passA", 0);

        start_op(3'd6, 128'h6666, 128'h1, 4'd10);
        finish_op("op6", 0);
        start_op(3'd7, 128'h7777, 128'h2, 4'd11);
        finish_op("op7", 0);
        start_op(3'd2, 128'hF0, 128'h0F, 4'd4);
        finish_op("add2", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
